pipelined_shifter: RTL and testbench

PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

---
 rtl/pipelined_shifter.sv | 126 ++++++++++++
 tb/tb_pipelined_shifter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROR), one shift stage per shamt bit.
// Define SHIFTER_ROTATE_EN to enable ROR on op 11; otherwise op 11 behaves as SRL.
module pipelined_shifter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic             stall;

  logic             vld_q  [SHW];
  logic [WIDTH-1:0] data_q [SHW];
  logic [SHW-1:0]   sh_q   [SHW];
  logic [1:0]       op_q   [SHW];
  logic [TAG_W-1:0] tag_q  [SHW];
  logic             fill_q [SHW];

  logic             vld_d  [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [SHW-1:0]   sh_d   [SHW];
  logic [1:0]       op_d   [SHW];
  logic [TAG_W-1:0] tag_d  [SHW];
  logic             fill_d [SHW];

  logic             src_vld  [SHW];
  logic [WIDTH-1:0] src_data [SHW];
  logic [SHW-1:0]   src_sh   [SHW];
  logic [1:0]       src_op   [SHW];
  logic [TAG_W-1:0] src_tag  [SHW];
  logic             src_fill [SHW];

  // Right shifts OR in the carried fill bit (1 only for SRA of a negative operand).
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       op,
                                                   input logic             fill,
                                                   input int unsigned      s);
    logic [WIDTH-1:0] res;
    res = (d >> s) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> s));
    if (op == OP_SLL) begin
      res = d << s;
    end
`ifdef SHIFTER_ROTATE_EN
    else if (op == 2'b11) begin
      res = (d >> s) | (d << (WIDTH - s));
    end
`endif
    return res;
  endfunction

  assign stall     = vld_q[SHW-1] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = vld_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_tag   = tag_q[SHW-1];

  always_comb begin
    src_vld[0]  = in_valid;
    src_data[0] = in_data;
    src_sh[0]   = in_shamt;
    src_op[0]   = in_op;
    src_tag[0]  = in_tag;
    src_fill[0] = (in_op == OP_SRA) && in_data[WIDTH-1];
    for (int k = 1; k < SHW; k++) begin
      src_vld[k]  = vld_q[k-1];
      src_data[k] = data_q[k-1];
      src_sh[k]   = sh_q[k-1];
      src_op[k]   = op_q[k-1];
      src_tag[k]  = tag_q[k-1];
      src_fill[k] = fill_q[k-1];
    end
  end

  // Stage k applies the 2^(SHW-1-k) shift, so the largest shift happens first.
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      vld_d[k]  = src_vld[k];
      sh_d[k]   = src_sh[k];
      op_d[k]   = src_op[k];
      tag_d[k]  = src_tag[k];
      fill_d[k] = src_fill[k];
      data_d[k] = src_data[k];
      if (src_sh[k][SHW-1-k]) begin
        data_d[k] = stage_shift(src_data[k], src_op[k], src_fill[k], 1 << (SHW - 1 - k));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SHW; k++) begin
        vld_q[k]  <= 1'b0;
        data_q[k] <= '0;
        sh_q[k]   <= '0;
        op_q[k]   <= '0;
        tag_q[k]  <= '0;
        fill_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < SHW; k++) begin
        vld_q[k]  <= vld_d[k];
        data_q[k] <= data_d[k];
        sh_q[k]   <= sh_d[k];
        op_q[k]   <= op_d[k];
        tag_q[k]  <= tag_d[k];
        fill_q[k] <= fill_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter at WIDTH=32, TAG_W=5 (5-cycle latency).
module tb_pipelined_shifter;
  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int SHW   = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  int npass  = 0;
  int ntotal = 0;
  int issued, collected, hold, cyc, hits;
  bit seen;

  always #5 clock = ~clock;

  pipelined_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] d,
                       input logic [4:0] sh, input logic [4:0] tag);
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    in_tag   = tag;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] sh, input logic [4:0] tag, input logic [31:0] exp);
    drive(op, d, sh, tag);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk({name, "_early"}, 64'(out_valid), 64'd0);
    step();
    chk({name, "_vld"},  64'(out_valid), 64'd1);
    chk({name, "_data"}, 64'(out_data),  64'(exp));
    chk({name, "_tag"},  64'(out_tag),   64'(tag));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(2'b00, 32'hFFFF_FFFF, 5'd0, 5'd7);
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    reset    = 1'b0;
    in_valid = 1'b0;
    hits = 0;
    repeat (6) begin
      if (out_valid) hits++;
      step();
    end
    chk("rst_discard", 64'(hits), 64'd0);

    run_op("sra_neg",  2'b10, 32'h8000_0000, 5'd4,  5'd3,  32'hF800_0000);
    run_op("srl",      2'b01, 32'h8000_0000, 5'd4,  5'd4,  32'h0800_0000);
    run_op("sll31",    2'b00, 32'h0000_0001, 5'd31, 5'd5,  32'h8000_0000);
    run_op("sll16",    2'b00, 32'hDEAD_BEEF, 5'd16, 5'd6,  32'hBEEF_0000);
    run_op("sra_pos",  2'b10, 32'h7000_0000, 5'd4,  5'd7,  32'h0700_0000);
    run_op("sra31",    2'b10, 32'h8000_0001, 5'd31, 5'd12, 32'hFFFF_FFFF);
    run_op("z_sll",    2'b00, 32'hDEAD_BEEF, 5'd0,  5'd8,  32'hDEAD_BEEF);
    run_op("z_srl",    2'b01, 32'hDEAD_BEEF, 5'd0,  5'd9,  32'hDEAD_BEEF);
    run_op("z_sra",    2'b10, 32'hDEAD_BEEF, 5'd0,  5'd10, 32'hDEAD_BEEF);
    run_op("z_ror",    2'b11, 32'hDEAD_BEEF, 5'd0,  5'd11, 32'hDEAD_BEEF);
`ifdef SHIFTER_ROTATE_EN
    run_op("ror8",     2'b11, 32'h1234_5678, 5'd8,  5'd13, 32'h7812_3456);
`else
    run_op("ror8",     2'b11, 32'h1234_5678, 5'd8,  5'd13, 32'h0012_3456);
`endif

    // Seven back-to-back SLLs of 1 by tag; consumer blocks 4 cycles once the first result appears.
    issued    = 0;
    collected = 0;
    hold      = 0;
    cyc       = 0;
    seen      = 1'b0;
    while ((issued < 7 || collected < 7) && cyc < 60) begin
      in_valid = (issued < 7);
      drive(2'b00, 32'h0000_0001, issued[4:0], issued[4:0]);
      if (!seen && out_valid) begin
        seen = 1'b1;
        hold = 4;
      end
      out_ready = (hold == 0);
      #1;
      if (hold > 0) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        hold--;
      end
      if (out_valid && out_ready) begin
        chk("b2b_tag",  64'(out_tag),  64'(collected));
        chk("b2b_data", 64'(out_data), 64'(32'h1 << collected));
        collected++;
      end
      if (in_valid && in_ready) issued++;
      cyc++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("b2b_count", 64'(collected), 64'd7);
    chk("b2b_issued", 64'(issued), 64'd7);
    step();
    chk("b2b_drained", 64'(out_valid), 64'd0);

    // Three ops in flight; reset on the third cycle flushes them all.
    in_valid = 1'b1;
    drive(2'b01, 32'hFFFF_0000, 5'd1, 5'd21);
    step();
    drive(2'b01, 32'hFFFF_0000, 5'd2, 5'd22);
    step();
    drive(2'b01, 32'hFFFF_0000, 5'd3, 5'd23);
    reset = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("flush_data", 64'(out_data), 64'd0);
    chk("flush_tag",  64'(out_tag),  64'd0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("flush_vld%0d", i), 64'(out_valid), 64'd0);
      step();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
